pulse_cmd_frame_tx: RTL and testbench
=====================================

// Module: pulse_cmd_frame_tx
// PURPOSE
//  Builds and transmits the 9-byte pulse-command frame consumed by the pulse-generator command receiver:
//  07, EN1, EN2, W1_H, W1_L, W2_H, W2_L, GAP_H, GAP_L.
//  Feeds uart_tx byte by byte through its pi_data/pi_flag interface, pacing bytes by a fixed byte-time counter.
//  uart_tx has no busy output.
//  Used by a master board to program and fire a remote pulse generator, and for loopback self-test.
// PARAMETERS
//  UART_BPS    9600        serial baud rate; must match the uart_tx instance
//  CLK_FREQ    50_000_000  sys_clk frequency, Hz
//  GUARD_CLKS  5208        extra idle clocks after each 10-bit byte time (one bit at defaults)
//  HEADER      8'h07       frame header byte
// PORTS
//  sys_clk       in   1   system clock, 50 MHz
//  sys_rst_n     in   1   asynchronous reset, active low
//  start         in   1   1-cycle request to send one frame
//  enable1       in   1   channel-1 pulse enable
//  enable2       in   1   channel-2 pulse enable
//  pulse_width1  in   16  channel-1 width, 10 ns units
//  pulse_width2  in   16  channel-2 width, 10 ns units
//  pulse_gap     in   16  inter-pulse gap, 10 ns units
//  busy          out  1   high from accepted start until done
//  done          out  1   1-cycle pulse when the last byte's slot expires
//  pi_data       out  8   byte to uart_tx
//  pi_flag       out  1   1-cycle strobe to uart_tx; pi_data valid in the same cycle
// BEHAVIOUR
//  - Derived constants:
//    - BIT_CLKS = CLK_FREQ/UART_BPS (integer division).
//    - BYTE_CLKS = 10*BIT_CLKS + GUARD_CLKS; at the defaults this is 57288.
//    - The slot counter is wide enough for BYTE_CLKS-1.
//  - Reset (async, sys_rst_n low):
//    - state=IDLE; busy=0, done=0, pi_flag=0, pi_data=8'h00.
//    - byte index=0, slot counter=0, field latches=0.
//    - Mid-frame reset aborts the frame immediately; no partial-frame resume.
//  - States: IDLE -> SEND -> WAIT -> (SEND | FIN) -> IDLE.
//    - IDLE:
//      - On start=1: latch all six field inputs and set busy=1 on the next edge.
//      - Go to SEND with index=0.
//      - start=0 keeps IDLE.
//    - SEND (1 cycle):
//      - pi_data=frame[index], pi_flag=1.
//      - Slot counter cleared; go to WAIT.
//    - WAIT:
//      - pi_flag=0; pi_data holds its last value.
//      - The counter runs 0..BYTE_CLKS-2.
//      - At terminal count: if index=8 go to FIN, else index+1 and go to SEND.
//    - FIN (1 cycle): done=1, busy=0 at the following edge; go to IDLE.
//  - Frame bytes come from the latched fields. MSB first within each 16-bit field:
//    - [0] HEADER
//    - [1] {7'b0,enable1}
//    - [2] {7'b0,enable2}
//    - [3] width1[15:8], [4] width1[7:0]
//    - [5] width2[15:8], [6] width2[7:0]
//    - [7] gap[15:8],    [8] gap[7:0]
//    - Values are sent unclamped. The receiver enforces its own minimum of 4.
//  - Timing:
//    - start sampled at edge N gives the first pi_flag in cycle N+1.
//    - Successive pi_flag pulses are exactly BYTE_CLKS cycles apart; exactly 9 pi_flag pulses per frame.
//    - done is asserted BYTE_CLKS cycles after the 9th pi_flag.
//    - busy is high in every cycle from N+1 up to and including the done cycle.
//  - Boundary cases:
//    - start while busy=1 is ignored, not queued.
//    - start in the same cycle as done is ignored. A new frame needs start with busy=0.
//    - Field inputs changing while busy do not affect the frame in flight.
//    - A start pulse wider than 1 cycle sends one frame; the extra cycles fall while busy.
//    - All-zero fields are legal and produce 07 00 00 00 00 00 00 00 00.
// TESTING (bench overrides CLK_FREQ=100, UART_BPS=10, GUARD_CLKS=10, giving BYTE_CLKS=110)
//  1. en1=1, en2=0, w1=16'h0102, w2=16'h0005, gap=16'h0304, start -> pi_flag x9, each 110 clks apart,
//     bytes 07 01 00 01 02 00 05 03 04; one done pulse; busy falls with done.
//  2. Same fields via real uart_tx -> uart_rx loopback at defaults -> receiver sees the 9 bytes in order;
//     the pulse generator fires on channel 1.
//  3. start pulses at byte indices 3 and 8 of a running frame -> still exactly 9 bytes; no second frame;
//     busy stays continuous.
//  4. Assert sys_rst_n=0 during WAIT of byte 5 -> pi_flag=0, busy=0 asynchronously. Release reset, then start
//     -> full frame from byte 07.
//  5. Change w1 to 16'hFFFF after start, during byte 1 -> frame still carries the originally latched w1 bytes.
//  6. start coincident with done, then start 1 cycle later -> first ignored; second frame's first pi_flag
//     follows 1 cycle after the accepted start.

Source files
------------

// File: rtl/pulse_cmd_frame_tx.sv
// Pulse-command frame transmitter: sends 07,EN1,EN2,W1,W2,GAP to uart_tx.
// Bytes are paced by a fixed byte-time slot because uart_tx has no busy.
module pulse_cmd_frame_tx #(
  parameter int          UART_BPS   = 9600,
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          GUARD_CLKS = 5208,
  parameter logic [7:0]  HEADER     = 8'h07
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        enable1,
  input  logic        enable2,
  input  logic [15:0] pulse_width1,
  input  logic [15:0] pulse_width2,
  input  logic [15:0] pulse_gap,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pi_data,
  output logic        pi_flag
);

  localparam int BIT_CLKS  = CLK_FREQ / UART_BPS;
  localparam int BYTE_CLKS = 10 * BIT_CLKS + GUARD_CLKS;
  localparam int CW        = $clog2(BYTE_CLKS);
  localparam logic [CW-1:0] TERM = CW'(BYTE_CLKS - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_FIN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_idx;
  logic [3:0]      w_nidx;
  logic [7:0]      r_data;
  logic [7:0]      w_byte;
  logic            r_busy;
  logic            r_en1;
  logic            r_en2;
  logic [15:0]     r_w1;
  logic [15:0]     r_w2;
  logic [15:0]     r_gap;
  logic            w_term;

  assign w_term = (r_cnt == TERM);
  assign w_nidx = r_idx + 4'd1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_SEND;
      S_SEND: w_next = S_WAIT;
      S_WAIT: begin
        if (w_term) w_next = (r_idx == 4'd8) ? S_FIN : S_SEND;
      end
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Byte for the next slot, taken from the latched fields only
  always_comb begin
    w_byte = HEADER;
    case (w_nidx)
      4'd1:    w_byte = {7'b0, r_en1};
      4'd2:    w_byte = {7'b0, r_en2};
      4'd3:    w_byte = r_w1[15:8];
      4'd4:    w_byte = r_w1[7:0];
      4'd5:    w_byte = r_w2[15:8];
      4'd6:    w_byte = r_w2[7:0];
      4'd7:    w_byte = r_gap[15:8];
      4'd8:    w_byte = r_gap[7:0];
      default: w_byte = HEADER;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_data <= '0;
      r_busy <= 1'b0;
      r_en1  <= 1'b0;
      r_en2  <= 1'b0;
      r_w1   <= '0;
      r_w2   <= '0;
      r_gap  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_en1  <= enable1;
            r_en2  <= enable2;
            r_w1   <= pulse_width1;
            r_w2   <= pulse_width2;
            r_gap  <= pulse_gap;
            r_busy <= 1'b1;
            r_idx  <= '0;
            r_data <= HEADER;
          end
        end
        S_SEND: r_cnt <= '0;
        S_WAIT: begin
          if (w_term) begin
            if (r_idx != 4'd8) begin
              r_idx  <= w_nidx;
              r_data <= w_byte;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIN:  r_busy <= 1'b0;
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = (r_state == S_FIN);
  assign pi_flag = (r_state == S_SEND);
  assign pi_data = r_data;

endmodule

// File: tb/tb_pulse_cmd_frame_tx.sv
// Bench for pulse_cmd_frame_tx: frame contents, slot timing, busy/done,
// start filtering, field isolation and mid-frame reset.
module tb_pulse_cmd_frame_tx;

  localparam int BYTE = 110;
  localparam int LOGN = 32768;

  typedef logic [8:0][7:0] frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        en1 = 1'b0;
  logic        en2 = 1'b0;
  logic [15:0] w1 = '0;
  logic [15:0] w2 = '0;
  logic [15:0] gap = '0;
  logic        busy;
  logic        done;
  logic [7:0]  pi_data;
  logic        pi_flag;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int         fcyc_q[$];
  logic [7:0] fdat_q[$];
  int         done_q[$];
  logic       busy_log[0:LOGN-1];

  pulse_cmd_frame_tx #(
    .UART_BPS  (10),
    .CLK_FREQ  (100),
    .GUARD_CLKS(10),
    .HEADER    (8'h07)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .start       (start),
    .enable1     (en1),
    .enable2     (en2),
    .pulse_width1(w1),
    .pulse_width2(w2),
    .pulse_gap   (gap),
    .busy        (busy),
    .done        (done),
    .pi_data     (pi_data),
    .pi_flag     (pi_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pi_flag) begin
      fcyc_q.push_back(cyc);
      fdat_q.push_back(pi_data);
    end
    if (done) done_q.push_back(cyc);
    if (cyc < LOGN) busy_log[cyc] = busy;
  end

  function automatic frame_t build(input logic e1, input logic e2,
                                   input int a, input int b, input int g);
    frame_t f;
    f[0] = 8'h07;
    f[1] = e1 ? 8'd1 : 8'd0;
    f[2] = e2 ? 8'd1 : 8'd0;
    f[3] = 8'(a / 256);
    f[4] = 8'(a % 256);
    f[5] = 8'(b / 256);
    f[6] = 8'(b % 256);
    f[7] = 8'(g / 256);
    f[8] = 8'(g % 256);
    return f;
  endfunction

  task automatic set_fields(input logic e1, input logic e2,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] g);
    en1 = e1;
    en2 = e2;
    w1  = a;
    w2  = b;
    gap = g;
  endtask

  // mode 0 plain, 1 starts mid-frame, 2 w1 change, 3 wide start,
  // 4 start on done cycle and the next cycle (returns new k)
  task automatic run_frame(input string nm, input int mode,
                           input bit pre, inout int k);
    frame_t ex;
    int last;
    int bad;
    ex = build(en1, en2, int'(w1), int'(w2), int'(gap));
    fcyc_q.delete();
    fdat_q.delete();
    done_q.delete();
    if (!pre) begin
      @(posedge clk); #1;
      k = cyc;
      start = 1'b1;
    end
    last = (mode == 4) ? 992 : 996;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      case (mode)
        1:       start = (c == 350 || c == 900);
        3:       start = (c < 3);
        4:       start = (c == 991 || c == 992);
        default: start = 1'b0;
      endcase
      if (mode == 2 && c == 115) w1 = 16'hFFFF;
    end
    n_cmp++;
    if (fcyc_q.size() != 9) begin
      n_err++;
      $display("FAIL %s flag_count got %0d want 9", nm, fcyc_q.size());
    end
    for (int i = 0; i < 9 && i < fcyc_q.size(); i++) begin
      n_cmp++;
      if (fcyc_q[i] != k + 1 + BYTE * i) begin
        n_err++;
        $display("FAIL %s flag%0d_cycle got %0d want %0d",
                 nm, i, fcyc_q[i] - k, 1 + BYTE * i);
      end
      n_cmp++;
      if (fdat_q[i] !== ex[i]) begin
        n_err++;
        $display("FAIL %s byte%0d got %02h want %02h",
                 nm, i, fdat_q[i], ex[i]);
      end
    end
    n_cmp++;
    if (done_q.size() != 1) begin
      n_err++;
      $display("FAIL %s done_count got %0d want 1", nm, done_q.size());
    end else begin
      n_cmp++;
      if (done_q[0] != k + 1 + 9 * BYTE) begin
        n_err++;
        $display("FAIL %s done_cycle got %0d want %0d",
                 nm, done_q[0] - k, 1 + 9 * BYTE);
      end
    end
    bad = 0;
    for (int c = k + 1; c <= k + 1 + 9 * BYTE; c++)
      if (c < LOGN && busy_log[c] !== 1'b1) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s busy_gaps got %0d want 0", nm, bad);
    end
    if (mode != 4) begin
      n_cmp++;
      if (busy_log[k + 2 + 9 * BYTE] !== 1'b0) begin
        n_err++;
        $display("FAIL %s busy_after_done got %b want 0",
                 nm, busy_log[k + 2 + 9 * BYTE]);
      end
    end else begin
      k = k + 992;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, pi_flag, pi_data} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %b%b%b %02h want 0 0 0 00",
               busy, done, pi_flag, pi_data);
    end
    rst_n = 1'b1;
    fcyc_q.delete();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (fcyc_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_quiet got flags=%0d busy=%b want 0 0",
               fcyc_q.size(), busy);
    end
  endtask

  task automatic test_basic();
    int k;
    set_fields(1'b1, 1'b0, 16'h0102, 16'h0005, 16'h0304);
    run_frame("basic", 0, 1'b0, k);
  endtask

  task automatic test_start_while_busy();
    int k;
    set_fields(1'b0, 1'b1, 16'h1234, 16'hABCD, 16'h00FF);
    run_frame("start_busy", 1, 1'b0, k);
  endtask

  task automatic test_reset_midframe();
    int k;
    set_fields(1'b1, 1'b1, 16'h5555, 16'hAAAA, 16'h0F0F);
    fcyc_q.delete();
    @(posedge clk); #1;
    k = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < k + 590) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (fcyc_q.size() != 6) begin
      n_err++;
      $display("FAIL midrst_pre_flags got %0d want 6", fcyc_q.size());
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, pi_flag, pi_data} !== 11'd0) begin
      n_err++;
      $display("FAIL midrst_async got %b%b%b %02h want 0 0 0 00",
               busy, done, pi_flag, pi_data);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    n_cmp++;
    if (fcyc_q.size() != 6 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_no_resume got flags=%0d busy=%b want 6 0",
               fcyc_q.size(), busy);
    end
    set_fields(1'b0, 1'b1, 16'h0A0B, 16'h0C0D, 16'h0E0F);
    run_frame("after_reset", 0, 1'b0, k);
  endtask

  task automatic test_field_change();
    int k;
    set_fields(1'b1, 1'b0, 16'h0102, 16'h0005, 16'h0304);
    run_frame("field_change", 2, 1'b0, k);
  endtask

  task automatic test_wide_start();
    int k;
    set_fields(1'b1, 1'b1, 16'h00C8, 16'h0190, 16'h03E8);
    run_frame("wide_start", 3, 1'b0, k);
  endtask

  task automatic test_back_to_back();
    int k;
    set_fields(1'b0, 1'b0, 16'h7777, 16'h8888, 16'h9999);
    run_frame("done_start1", 4, 1'b0, k);
    run_frame("done_start2", 0, 1'b1, k);
  endtask

  task automatic test_zero();
    int k;
    set_fields(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    run_frame("all_zero", 0, 1'b0, k);
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 3; n++) begin
      set_fields(1'($urandom), 1'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom));
      run_frame("random", 0, 1'b0, k);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_while_busy();
    test_reset_midframe();
    test_field_change();
    test_wide_start();
    test_back_to_back();
    test_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
